// File: rtl/rf_pkg.sv
// rf_pkg: shared state type, default sizes and one-hot decode helper for the register-file sequencer
package rf_pkg;
    localparam int RF_W = 16;
    localparam int RF_NREGS = 8;
    localparam int RF_MAXREGS = 16;
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
    function automatic logic [RF_MAXREGS-1:0] onehot_dec(input logic [3:0] addr, input logic en, input int unsigned nregs = RF_NREGS);
        return (en && 32'(addr) < nregs) ? RF_MAXREGS'(1) << addr : '0;
    endfunction
endpackage

// File: rtl/rf_access_ctrl_if.sv
// rf_access_ctrl_if: command/response handshakes plus the register-bank enable and data buses
interface rf_access_ctrl_if import rf_pkg::*; #(
    parameter int NREGS = RF_NREGS,
    parameter int W = RF_W,
    parameter int AW = $clog2(NREGS)
);
    logic req_valid, req_ready, req_we;
    logic [AW-1:0] req_ra, req_rb, req_wa;
    logic [W-1:0] req_wdata;
    logic [NREGS-1:0] ld, oeA, oeB;
    logic [W-1:0] Din, DA, DB;
    logic rsp_valid, rsp_ready;
    logic [W-1:0] rsp_a, rsp_b;
    modport slave (
        input req_valid, req_we, req_ra, req_rb, req_wa, req_wdata, DA, DB, rsp_ready,
        output req_ready, ld, oeA, oeB, Din, rsp_valid, rsp_a, rsp_b
    );
    modport master (
        output req_valid, req_we, req_ra, req_rb, req_wa, req_wdata, DA, DB, rsp_ready,
        input req_ready, ld, oeA, oeB, Din, rsp_valid, rsp_a, rsp_b
    );
endinterface

// File: rtl/rf_onehot_dec.sv
// rf_onehot_dec: address to one-hot enable decoder, all-zero when disabled or out of range
module rf_onehot_dec import rf_pkg::*; #(
    parameter int NREGS = RF_NREGS,
    parameter int AW = $clog2(NREGS)
) (
    input  logic [AW-1:0]    addr,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);
    assign onehot = NREGS'(onehot_dec(4'(addr), en, NREGS));
endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: read-then-optional-write sequencer driving register-bank enables over valid/ready channels
module rf_access_ctrl import rf_pkg::*; #(
    parameter int NREGS = RF_NREGS,
    parameter int W = RF_W,
    parameter int AW = $clog2(NREGS)
) (
    input logic clk,
    input logic reset,
    rf_access_ctrl_if.slave bus
);
    state_t state, nxt;
    logic we_q;
    logic [AW-1:0] ra_q, rb_q, wa_q;
    logic [W-1:0] wdata_q, din_q;
    rf_onehot_dec #(.NREGS(NREGS), .AW(AW)) u_dec_a (.addr(ra_q), .en(state == RD), .onehot(bus.oeA));
    rf_onehot_dec #(.NREGS(NREGS), .AW(AW)) u_dec_b (.addr(rb_q), .en(state == RD), .onehot(bus.oeB));
    rf_onehot_dec #(.NREGS(NREGS), .AW(AW)) u_dec_w (.addr(wa_q), .en(state == WR), .onehot(bus.ld));
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RSP;
    assign bus.Din = state == WR ? wdata_q : din_q;
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = bus.req_valid ? RD : IDLE;
            RD: nxt = we_q ? WR : RSP;
            WR: nxt = RSP;
            RSP: nxt = bus.rsp_ready ? IDLE : RSP;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= nxt;
    // an undriven bus floats, so an operand with no oe bit is captured as zero
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            we_q <= 1'b0;
            ra_q <= '0;
            rb_q <= '0;
            wa_q <= '0;
            wdata_q <= '0;
            din_q <= '0;
            bus.rsp_a <= '0;
            bus.rsp_b <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                we_q <= bus.req_we;
                ra_q <= bus.req_ra;
                rb_q <= bus.req_rb;
                wa_q <= bus.req_wa;
                wdata_q <= bus.req_wdata;
            end
            if (state == RD) begin
                bus.rsp_a <= |bus.oeA ? bus.DA : '0;
                bus.rsp_b <= |bus.oeB ? bus.DB : '0;
            end
            if (state == WR) din_q <= wdata_q;
        end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed vector table plus stall, reset, out-of-range and random bank-model sequences
module tb_rf_access_ctrl;
    import rf_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    rf_access_ctrl_if #(.NREGS(8)) bus ();
    rf_access_ctrl_if #(.NREGS(6)) bus6 ();
    rf_access_ctrl #(.NREGS(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    rf_access_ctrl #(.NREGS(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6.slave));
    typedef struct {
        logic we;
        logic [2:0] ra, rb, wa;
        logic [15:0] wdata, exp_a, exp_b;
        logic [7:0] exp_oea, exp_oeb, exp_ld;
    } vec_t;
    logic sel = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [2:0] req_ra = '0, req_rb = '0, req_wa = '0;
    logic [15:0] req_wdata = '0;
    assign bus.req_valid = req_valid & ~sel;
    assign bus6.req_valid = req_valid & sel;
    assign bus.req_we = req_we;
    assign bus6.req_we = req_we;
    assign bus.req_ra = req_ra;
    assign bus6.req_ra = req_ra;
    assign bus.req_rb = req_rb;
    assign bus6.req_rb = req_rb;
    assign bus.req_wa = req_wa;
    assign bus6.req_wa = req_wa;
    assign bus.req_wdata = req_wdata;
    assign bus6.req_wdata = req_wdata;
    assign bus.rsp_ready = rsp_ready;
    assign bus6.rsp_ready = rsp_ready;
    logic [7:0] oea, oeb, ld;
    logic rq_rdy, rs_vld;
    logic [15:0] din, rsp_a, rsp_b;
    always_comb begin
        oea = sel ? {2'b00, bus6.oeA} : bus.oeA;
        oeb = sel ? {2'b00, bus6.oeB} : bus.oeB;
        ld = sel ? {2'b00, bus6.ld} : bus.ld;
        rq_rdy = sel ? bus6.req_ready : bus.req_ready;
        rs_vld = sel ? bus6.rsp_valid : bus.rsp_valid;
        din = sel ? bus6.Din : bus.Din;
        rsp_a = sel ? bus6.rsp_a : bus.rsp_a;
        rsp_b = sel ? bus6.rsp_b : bus.rsp_b;
    end
    // bank model: an undriven bus reads as junk so a forced-zero operand is visible
    logic [15:0] bank [8];
    logic pl_en = 1'b0;
    logic [2:0] pl_idx = '0;
    logic [15:0] pl_val = '0;
    always @(posedge clk)
        if (pl_en) bank[pl_idx] <= pl_val;
        else for (int i = 0; i < 8; i++) if (bus.ld[i]) bank[i] <= bus.Din;
    always_comb begin
        bus.DA = 16'hDEAD;
        bus.DB = 16'hDEAD;
        for (int i = 0; i < 8; i++) begin
            if (bus.oeA[i]) bus.DA = bank[i];
            if (bus.oeB[i]) bus.DB = bank[i];
        end
    end
    assign bus6.DA = |bus6.oeA ? 16'h0A0A : 16'hDEAD;
    assign bus6.DB = |bus6.oeB ? 16'h0B0B : 16'hDEAD;
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    always @(negedge clk)
        if (!reset)
            chk("onehot0_enables", 32'($onehot0(bus.oeA) && $onehot0(bus.oeB) && $onehot0(bus.ld) &&
                $onehot0(bus6.oeA) && $onehot0(bus6.oeB) && $onehot0(bus6.ld)), 32'd1);
    task automatic run_cmd(input vec_t v, input int stall, input string name);
        int cyc, t_oe, t_ld, n_oe, n_ld;
        logic [7:0] sa, sb, sl;
        logic [15:0] din_s;
        chk({name, ".req_ready"}, 32'(rq_rdy), 32'd1);
        req_valid = 1'b1;
        req_we = v.we;
        req_ra = v.ra;
        req_rb = v.rb;
        req_wa = v.wa;
        req_wdata = v.wdata;
        rsp_ready = stall == 0;
        cyc = 0; t_oe = -1; t_ld = -1; n_oe = 0; n_ld = 0; sa = '0; sb = '0; sl = '0; din_s = '0;
        do begin
            @(posedge clk); #1;
            cyc++;
            req_valid = 1'b0;
            if (|oea || |oeb) begin sa |= oea; sb |= oeb; n_oe++; t_oe = cyc; end
            if (|ld) begin sl |= ld; n_ld++; t_ld = cyc; end
            if (cyc == 2 && v.we) din_s = din;
        end while (!rs_vld && cyc < 20);
        chk({name, ".latency"}, 32'(cyc), v.we ? 32'd3 : 32'd2);
        chk({name, ".oeA"}, 32'(sa), 32'(v.exp_oea));
        chk({name, ".oeB"}, 32'(sb), 32'(v.exp_oeb));
        chk({name, ".ld"}, 32'(sl), 32'(v.exp_ld));
        chk({name, ".oe_cycles"}, 32'(n_oe), 32'd1);
        chk({name, ".ld_cycles"}, 32'(n_ld), 32'(v.exp_ld != 0));
        if (v.exp_ld != 0) chk({name, ".ld_after_oe"}, 32'(t_ld), 32'(t_oe + 1));
        if (v.we) chk({name, ".Din"}, 32'(din_s), 32'(v.wdata));
        chk({name, ".rsp_a"}, 32'(rsp_a), 32'(v.exp_a));
        chk({name, ".rsp_b"}, 32'(rsp_b), 32'(v.exp_b));
        repeat (stall) begin
            @(posedge clk); #1;
            chk({name, ".stall_rsp_a"}, 32'(rsp_a), 32'(v.exp_a));
            chk({name, ".stall_rsp_b"}, 32'(rsp_b), 32'(v.exp_b));
            chk({name, ".stall_req_ready"}, 32'(rq_rdy), 32'd0);
            chk({name, ".stall_rsp_valid"}, 32'(rs_vld), 32'd1);
            chk({name, ".stall_enables"}, 32'({oea, oeb, ld}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, ".done_ready"}, 32'(rq_rdy), 32'd1);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
    initial begin
        vec_t vt [7];
        vec_t v6 [2];
        vec_t v;
        logic [15:0] init_v [8];
        logic [15:0] mb [8];
        init_v = '{16'hA000, 16'h1111, 16'h1234, 16'h0001, 16'h4444, 16'hABCD, 16'h6666, 16'h7777};
        vt[0] = '{1'b0, 3'd2, 3'd5, 3'd0, 16'h0000, 16'h1234, 16'hABCD, 8'h04, 8'h20, 8'h00};
        vt[1] = '{1'b1, 3'd3, 3'd0, 3'd3, 16'hBEEF, 16'h0001, 16'hA000, 8'h08, 8'h01, 8'h08};
        vt[2] = '{1'b0, 3'd3, 3'd3, 3'd0, 16'h0000, 16'hBEEF, 16'hBEEF, 8'h08, 8'h08, 8'h00};
        vt[3] = '{1'b1, 3'd7, 3'd1, 3'd7, 16'h5A5A, 16'h7777, 16'h1111, 8'h80, 8'h02, 8'h80};
        vt[4] = '{1'b0, 3'd7, 3'd6, 3'd0, 16'h0000, 16'h5A5A, 16'h6666, 8'h80, 8'h40, 8'h00};
        vt[5] = '{1'b1, 3'd0, 3'd0, 3'd0, 16'h0F0F, 16'hA000, 16'hA000, 8'h01, 8'h01, 8'h01};
        vt[6] = '{1'b0, 3'd0, 3'd4, 3'd0, 16'h0000, 16'h0F0F, 16'h4444, 8'h01, 8'h10, 8'h00};
        v6[0] = '{1'b1, 3'd7, 3'd1, 3'd6, 16'h1234, 16'h0000, 16'h0B0B, 8'h00, 8'h02, 8'h00};
        v6[1] = '{1'b1, 3'd5, 3'd6, 3'd5, 16'h4321, 16'h0A0A, 16'h0000, 8'h20, 8'h00, 8'h20};
        pl_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pl_idx = 3'(i);
            pl_val = init_v[i];
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset.enables", 32'({bus.oeA, bus.oeB, bus.ld}), 32'd0);
        chk("reset.Din", 32'(bus.Din), 32'd0);
        chk("reset.rsp", {bus.rsp_a, bus.rsp_b}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) run_cmd(vt[i], 0, $sformatf("vec%0d", i));
        run_cmd(vt[0], 5, "stall");
        sel = 1'b1;
        for (int i = 0; i < 2; i++) run_cmd(v6[i], 0, $sformatf("nregs6_%0d", i));
        sel = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_ra = 3'd1; req_rb = 3'd2; req_wa = 3'd4; req_wdata = 16'hCAFE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_rd.oeA_in_rd", 32'(oea), 32'h02);
        #2 reset = 1'b1;
        #1;
        chk("rst_rd.enables", 32'({oea, oeb, ld}), 32'd0);
        chk("rst_rd.req_ready", 32'(rq_rdy), 32'd1);
        chk("rst_rd.rsp_valid", 32'(rs_vld), 32'd0);
        chk("rst_rd.rsp", {rsp_a, rsp_b}, 32'd0);
        chk("rst_rd.Din", 32'(din), 32'd0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("rst_rd.no_ld", 32'(ld), 32'd0);
            chk("rst_rd.ready_after", 32'(rq_rdy), 32'd1);
        end
        v = '{1'b0, 3'd4, 3'd2, 3'd0, 16'h0000, 16'h4444, 16'h1234, 8'h10, 8'h04, 8'h00};
        run_cmd(v, 0, "rst_rd.r4_unwritten");
        mb = '{16'h0F0F, 16'h1111, 16'h1234, 16'hBEEF, 16'h4444, 16'hABCD, 16'h6666, 16'h5A5A};
        for (int n = 0; n < 40; n++) begin
            v.we = 1'($urandom_range(0, 1));
            v.ra = 3'($urandom_range(0, 7));
            v.rb = 3'($urandom_range(0, 7));
            v.wa = 3'($urandom_range(0, 7));
            v.wdata = 16'($urandom);
            v.exp_a = mb[v.ra];
            v.exp_b = mb[v.rb];
            v.exp_oea = 8'(1) << v.ra;
            v.exp_oeb = 8'(1) << v.rb;
            v.exp_ld = v.we ? 8'(1) << v.wa : 8'h00;
            run_cmd(v, 0, $sformatf("rand%0d", n));
            if (v.we) mb[v.wa] = v.wdata;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
